// File: rtl/sdram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_ctrl_pkg
//  Description : Shared types and constants for the SDRAM burst arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package sdram_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } arb_state_t;

   localparam logic DIR_WR = 1'b0;
   localparam logic DIR_RD = 1'b1;

   function automatic int port_idx_width(input int num_ports);
      return (num_ports > 1) ? $clog2(num_ports) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_select.sv
`default_nettype none
// ============================================================================
//  Module      : rr_select
//  Description : Combinational round-robin picker, first request at or above
//                the pointer with wrap-around.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_select
   import sdram_ctrl_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int IDX_W     = port_idx_width(NUM_PORTS)
)(
   input  logic [NUM_PORTS-1:0] i_req,
   input  logic [IDX_W-1:0]     i_ptr,
   output logic [IDX_W-1:0]     o_idx,
   output logic                 o_valid
);

   logic [IDX_W:0]   w_sum;
   logic [IDX_W-1:0] w_cand;

   // Walk offsets from highest to lowest so the smallest offset wins last.
   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      w_sum   = '0;
      w_cand  = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
         if (w_sum >= (IDX_W+1)'(NUM_PORTS)) begin
            w_sum = w_sum - (IDX_W+1)'(NUM_PORTS);
         end
         w_cand = w_sum[IDX_W-1:0];
         if (i_req[w_cand]) begin
            o_idx   = w_cand;
            o_valid = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sdram_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_burst_arbiter
//  Description : Round-robin arbiter sharing the sdram_core burst interface
//                between NUM_PORTS requesters, with a grant watchdog.
//  Revision    : 1.0  initial release
// ============================================================================
module sdram_burst_arbiter
   import sdram_ctrl_pkg::*;
#(
   parameter int NUM_PORTS       = 2,
   parameter int APP_ADDR_WIDTH  = 24,
   parameter int APP_BURST_WIDTH = 10,
   parameter int SDR_DQ_WIDTH    = 16,
   parameter int TIMEOUT         = 4095
)(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_PORTS-1:0]                 p_wr_req,
   input  logic [NUM_PORTS-1:0]                 p_rd_req,
   input  logic [NUM_PORTS*APP_BURST_WIDTH-1:0] p_len,
   input  logic [NUM_PORTS*APP_ADDR_WIDTH-1:0]  p_addr,
   input  logic [NUM_PORTS*SDR_DQ_WIDTH-1:0]    p_wr_data,
   output logic [NUM_PORTS-1:0]                 p_wr_data_req,
   output logic [SDR_DQ_WIDTH-1:0]              p_rd_data,
   output logic [NUM_PORTS-1:0]                 p_rd_valid,
   output logic [NUM_PORTS-1:0]                 p_done,
   output logic [NUM_PORTS-1:0]                 p_err,
   output logic                                 wr_burst_req,
   output logic [APP_BURST_WIDTH-1:0]           wr_burst_len,
   output logic [APP_ADDR_WIDTH-1:0]            wr_burst_addr,
   output logic [SDR_DQ_WIDTH-1:0]              wr_burst_data,
   input  logic                                 wr_burst_data_req,
   input  logic                                 wr_burst_finish,
   output logic                                 rd_burst_req,
   output logic [APP_BURST_WIDTH-1:0]           rd_burst_len,
   output logic [APP_ADDR_WIDTH-1:0]            rd_burst_addr,
   input  logic [SDR_DQ_WIDTH-1:0]              rd_burst_data,
   input  logic                                 rd_burst_data_valid,
   input  logic                                 rd_burst_finish,
   output logic                                 busy
);

   localparam int IDX_W  = port_idx_width(NUM_PORTS);
   localparam int WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   arb_state_t                 r_state;
   logic [IDX_W-1:0]           r_gnt;
   logic [IDX_W-1:0]           r_ptr;
   logic                       r_dir;
   logic                       r_wr_req;
   logic                       r_rd_req;
   logic [APP_BURST_WIDTH-1:0] r_len;
   logic [APP_ADDR_WIDTH-1:0]  r_addr;
   logic [WDOG_W-1:0]          r_wdog;
   logic [NUM_PORTS-1:0]       r_done;
   logic [NUM_PORTS-1:0]       r_perr;

   logic [NUM_PORTS-1:0]       w_any_req;
   logic [IDX_W-1:0]           w_sel_idx;
   logic                       w_sel_valid;
   logic                       w_fin;
   logic                       w_gnt_wr;
   logic                       w_gnt_rd;

   assign w_any_req = p_wr_req | p_rd_req;

   rr_select #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (IDX_W)
   ) u_rr_select (
      .i_req   (w_any_req),
      .i_ptr   (r_ptr),
      .o_idx   (w_sel_idx),
      .o_valid (w_sel_valid)
   );

   // Only the finish matching the granted direction ends a burst.
   assign w_fin = (r_dir == DIR_WR) ? wr_burst_finish : rd_burst_finish;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_gnt    <= '0;
         r_ptr    <= '0;
         r_dir    <= DIR_WR;
         r_wr_req <= 1'b0;
         r_rd_req <= 1'b0;
         r_len    <= '0;
         r_addr   <= '0;
         r_wdog   <= '0;
         r_done   <= '0;
         r_perr   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_sel_valid) begin
                  r_gnt    <= w_sel_idx;
                  r_dir    <= p_wr_req[w_sel_idx] ? DIR_WR : DIR_RD;
                  r_wr_req <= p_wr_req[w_sel_idx];
                  r_rd_req <= !p_wr_req[w_sel_idx];
                  r_len    <= p_len[w_sel_idx*APP_BURST_WIDTH +: APP_BURST_WIDTH];
                  r_addr   <= p_addr[w_sel_idx*APP_ADDR_WIDTH +: APP_ADDR_WIDTH];
                  r_wdog   <= '0;
                  r_state  <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (w_fin || (r_wdog == WDOG_W'(TIMEOUT))) begin
                  r_wr_req       <= 1'b0;
                  r_rd_req       <= 1'b0;
                  r_done[r_gnt]  <= 1'b1;
                  r_perr[r_gnt]  <= !w_fin;
                  r_state        <= ST_RELEASE;
               end else begin
                  r_wdog <= r_wdog + WDOG_W'(1);
               end
            end
            ST_RELEASE: begin
               r_done  <= '0;
               r_perr  <= '0;
               r_ptr   <= (r_gnt == IDX_W'(NUM_PORTS - 1)) ? '0 : r_gnt + IDX_W'(1);
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign w_gnt_wr = (r_state == ST_GRANT) && (r_dir == DIR_WR);
   assign w_gnt_rd = (r_state == ST_GRANT) && (r_dir == DIR_RD);

   for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
      assign p_wr_data_req[k] = wr_burst_data_req   && w_gnt_wr && (r_gnt == IDX_W'(k));
      assign p_rd_valid[k]    = rd_burst_data_valid && w_gnt_rd && (r_gnt == IDX_W'(k));
   end

   assign wr_burst_data = p_wr_data[r_gnt*SDR_DQ_WIDTH +: SDR_DQ_WIDTH];
   assign p_rd_data     = rd_burst_data;

   assign wr_burst_req  = r_wr_req;
   assign wr_burst_len  = r_len;
   assign wr_burst_addr = r_addr;
   assign rd_burst_req  = r_rd_req;
   assign rd_burst_len  = r_len;
   assign rd_burst_addr = r_addr;
   assign p_done        = r_done;
   assign p_err         = r_perr;
   assign busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sdram_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_burst_arbiter
//  Description : Directed self-checking bench for sdram_burst_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sdram_burst_arbiter;

   localparam int NP = 2;
   localparam int AW = 24;
   localparam int BW = 10;
   localparam int DW = 16;
   localparam int TO = 15;

   logic             clk = 1'b0;
   logic             rst;
   logic [NP-1:0]    p_wr_req, p_rd_req;
   logic [NP*BW-1:0] p_len;
   logic [NP*AW-1:0] p_addr;
   logic [NP*DW-1:0] p_wr_data;
   logic [NP-1:0]    p_wr_data_req, p_rd_valid, p_done, p_err;
   logic [DW-1:0]    p_rd_data;
   logic             wr_burst_req, rd_burst_req;
   logic [BW-1:0]    wr_burst_len, rd_burst_len;
   logic [AW-1:0]    wr_burst_addr, rd_burst_addr;
   logic [DW-1:0]    wr_burst_data, rd_burst_data;
   logic             wr_burst_data_req, wr_burst_finish;
   logic             rd_burst_data_valid, rd_burst_finish;
   logic             busy;

   int errors = 0;
   int checks = 0;

   sdram_burst_arbiter #(
      .NUM_PORTS(NP), .APP_ADDR_WIDTH(AW), .APP_BURST_WIDTH(BW),
      .SDR_DQ_WIDTH(DW), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .p_wr_req(p_wr_req), .p_rd_req(p_rd_req), .p_len(p_len), .p_addr(p_addr),
      .p_wr_data(p_wr_data), .p_wr_data_req(p_wr_data_req), .p_rd_data(p_rd_data),
      .p_rd_valid(p_rd_valid), .p_done(p_done), .p_err(p_err),
      .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
      .wr_burst_data(wr_burst_data), .wr_burst_data_req(wr_burst_data_req),
      .wr_burst_finish(wr_burst_finish),
      .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
      .rd_burst_data(rd_burst_data), .rd_burst_data_valid(rd_burst_data_valid),
      .rd_burst_finish(rd_burst_finish), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      p_wr_req = '0; p_rd_req = '0; p_len = '0; p_addr = '0; p_wr_data = '0;
      wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
      rd_burst_data = '0; rd_burst_data_valid = 1'b0; rd_burst_finish = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Plays the core for one burst: two data beats then finish. Returns the
   // p_done vector seen at finish+1 and leaves the bench at finish+2.
   task automatic run_burst(output logic [NP-1:0] done, output logic was_wr,
                            output logic [AW-1:0] addr, output logic [NP-1:0] vmask);
      int n;
      done = '0; was_wr = 1'b0; addr = '0; vmask = '0; n = 0;
      while (!(wr_burst_req || rd_burst_req) && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) return;
      was_wr = wr_burst_req;
      addr   = was_wr ? wr_burst_addr : rd_burst_addr;
      for (int i = 0; i < 2; i++) begin
         if (was_wr) wr_burst_data_req = 1'b1; else rd_burst_data_valid = 1'b1;
         #1;
         if (i == 0) vmask = was_wr ? p_wr_data_req : p_rd_valid;
         tick();
      end
      wr_burst_data_req = 1'b0; rd_burst_data_valid = 1'b0;
      if (was_wr) wr_burst_finish = 1'b1; else rd_burst_finish = 1'b1;
      tick();
      wr_burst_finish = 1'b0; rd_burst_finish = 1'b0;
      done = p_done;
      if (was_wr) p_wr_req = p_wr_req & ~done; else p_rd_req = p_rd_req & ~done;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (wr_burst_req !== 1'b0) begin errors++; $display("FAIL rst_wr_req: got %0b want 0", wr_burst_req); end
      checks++; if (rd_burst_req !== 1'b0) begin errors++; $display("FAIL rst_rd_req: got %0b want 0", rd_burst_req); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", busy); end
      checks++; if (p_done !== 2'b00) begin errors++; $display("FAIL rst_done: got %b want 00", p_done); end
      checks++; if (p_err !== 2'b00) begin errors++; $display("FAIL rst_err: got %b want 00", p_err); end
      checks++; if (wr_burst_len !== 10'd0) begin errors++; $display("FAIL rst_len: got %0d want 0", wr_burst_len); end
      checks++; if (rd_burst_addr !== 24'd0) begin errors++; $display("FAIL rst_addr: got %h want 0", rd_burst_addr); end
      wr_burst_data_req = 1'b1; rd_burst_data_valid = 1'b1;
      #1;
      checks++; if (p_wr_data_req !== 2'b00) begin errors++; $display("FAIL rst_wdreq_mask: got %b want 00", p_wr_data_req); end
      checks++; if (p_rd_valid !== 2'b00) begin errors++; $display("FAIL rst_rvalid_mask: got %b want 00", p_rd_valid); end
      wr_burst_data_req = 1'b0; rd_burst_data_valid = 1'b0;
   endtask

   task automatic test_write();
      int c0, c1;
      do_reset();
      p_wr_data = {16'h5A5A, 16'hA5A5};
      p_len[9:0] = 10'd8;
      p_addr[23:0] = 24'h000100;
      p_wr_req = 2'b01;
      tick();
      checks++; if (wr_burst_req !== 1'b1) begin errors++; $display("FAIL wr_req_t1: got %0b want 1", wr_burst_req); end
      checks++; if (rd_burst_req !== 1'b0) begin errors++; $display("FAIL wr_rdreq_t1: got %0b want 0", rd_burst_req); end
      checks++; if (wr_burst_len !== 10'd8) begin errors++; $display("FAIL wr_len: got %0d want 8", wr_burst_len); end
      checks++; if (wr_burst_addr !== 24'h000100) begin errors++; $display("FAIL wr_addr: got %h want 000100", wr_burst_addr); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %0b want 1", busy); end
      checks++; if (wr_burst_data !== 16'hA5A5) begin errors++; $display("FAIL wr_data_mux: got %h want a5a5", wr_burst_data); end
      rd_burst_finish = 1'b1;
      tick();
      rd_burst_finish = 1'b0;
      checks++; if (wr_burst_req !== 1'b1) begin errors++; $display("FAIL wr_ignore_rdfin: got %0b want 1", wr_burst_req); end
      c0 = 0; c1 = 0;
      for (int i = 0; i < 8; i++) begin
         wr_burst_data_req = 1'b1;
         #1;
         c0 += int'(p_wr_data_req[0]);
         c1 += int'(p_wr_data_req[1]);
         tick();
      end
      wr_burst_data_req = 1'b0;
      wr_burst_finish = 1'b1;
      tick();
      wr_burst_finish = 1'b0;
      p_wr_req = 2'b00;
      checks++; if (c0 !== 8) begin errors++; $display("FAIL wr_dreq0_count: got %0d want 8", c0); end
      checks++; if (c1 !== 0) begin errors++; $display("FAIL wr_dreq1_count: got %0d want 0", c1); end
      checks++; if (p_done !== 2'b01) begin errors++; $display("FAIL wr_done: got %b want 01", p_done); end
      checks++; if (p_err !== 2'b00) begin errors++; $display("FAIL wr_err: got %b want 00", p_err); end
      checks++; if (wr_burst_req !== 1'b0) begin errors++; $display("FAIL wr_req_drop: got %0b want 0", wr_burst_req); end
      tick();
      checks++; if (p_done !== 2'b00) begin errors++; $display("FAIL wr_done_pulse: got %b want 00", p_done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_idle: got %0b want 0", busy); end
   endtask

   task automatic test_rr_alternate();
      logic [NP-1:0] done, vm, exp;
      logic          ww;
      logic [AW-1:0] a, ea;
      do_reset();
      p_len  = {10'd4, 10'd4};
      p_addr = {24'h123456, 24'h000200};
      p_rd_req = 2'b11;
      for (int b = 0; b < 4; b++) begin
         run_burst(done, ww, a, vm);
         exp = (b % 2 == 0) ? 2'b01 : 2'b10;
         ea  = (b % 2 == 0) ? 24'h000200 : 24'h123456;
         checks++; if (done !== exp) begin errors++; $display("FAIL rr_done_%0d: got %b want %b", b, done, exp); end
         checks++; if (a !== ea) begin errors++; $display("FAIL rr_addr_%0d: got %h want %h", b, a, ea); end
         checks++; if (vm !== exp) begin errors++; $display("FAIL rr_rvalid_%0d: got %b want %b", b, vm, exp); end
         checks++; if (ww !== 1'b0) begin errors++; $display("FAIL rr_dir_%0d: got %0b want 0", b, ww); end
         p_rd_req = p_rd_req | done;
      end
      p_rd_req = 2'b00;
      tick(); tick(); tick();
   endtask

   task automatic test_wr_then_rd();
      logic [NP-1:0] done, vm;
      logic          ww;
      logic [AW-1:0] a;
      do_reset();
      p_len  = {10'd2, 10'd0};
      p_addr = {24'h00ABCD, 24'h0};
      p_wr_req = 2'b10;
      p_rd_req = 2'b10;
      run_burst(done, ww, a, vm);
      checks++; if (ww !== 1'b1) begin errors++; $display("FAIL wrrd_first_dir: got %0b want 1", ww); end
      checks++; if (done !== 2'b10) begin errors++; $display("FAIL wrrd_first_done: got %b want 10", done); end
      checks++; if (vm !== 2'b10) begin errors++; $display("FAIL wrrd_wdreq_mask: got %b want 10", vm); end
      run_burst(done, ww, a, vm);
      checks++; if (ww !== 1'b0) begin errors++; $display("FAIL wrrd_second_dir: got %0b want 0", ww); end
      checks++; if (done !== 2'b10) begin errors++; $display("FAIL wrrd_second_done: got %b want 10", done); end
      checks++; if (a !== 24'h00ABCD) begin errors++; $display("FAIL wrrd_addr: got %h want 00abcd", a); end
   endtask

   task automatic test_timeout();
      int cnt;
      do_reset();
      p_rd_req = 2'b01;
      tick();
      cnt = 0;
      while (rd_burst_req === 1'b1 && cnt < 40) begin
         if (cnt == 3) begin
            rd_burst_data = 16'hBEEF;
            rd_burst_data_valid = 1'b1;
            #1;
            checks++; if (p_rd_valid !== 2'b01) begin errors++; $display("FAIL to_rvalid: got %b want 01", p_rd_valid); end
            checks++; if (p_rd_data !== 16'hBEEF) begin errors++; $display("FAIL to_rdata: got %h want beef", p_rd_data); end
            rd_burst_data_valid = 1'b0;
         end
         cnt++;
         tick();
      end
      checks++; if (cnt !== 16) begin errors++; $display("FAIL to_grant_cycles: got %0d want 16", cnt); end
      checks++; if (p_done !== 2'b01) begin errors++; $display("FAIL to_done: got %b want 01", p_done); end
      checks++; if (p_err !== 2'b01) begin errors++; $display("FAIL to_err: got %b want 01", p_err); end
      p_rd_req = 2'b00;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: got %0b want 0", busy); end
      checks++; if (p_err !== 2'b00) begin errors++; $display("FAIL to_err_pulse: got %b want 00", p_err); end
   endtask

   task automatic test_fin_at_expiry();
      do_reset();
      p_rd_req = 2'b01;
      tick();
      repeat (15) tick();
      checks++; if (rd_burst_req !== 1'b1) begin errors++; $display("FAIL fx_req_cycle16: got %0b want 1", rd_burst_req); end
      rd_burst_finish = 1'b1;
      tick();
      rd_burst_finish = 1'b0;
      p_rd_req = 2'b00;
      checks++; if (p_done !== 2'b01) begin errors++; $display("FAIL fx_done: got %b want 01", p_done); end
      checks++; if (p_err !== 2'b00) begin errors++; $display("FAIL fx_err: got %b want 00", p_err); end
      tick();
   endtask

   task automatic test_reset_mid_grant();
      logic [NP-1:0] done, vm;
      logic          ww;
      logic [AW-1:0] a;
      do_reset();
      p_rd_req = 2'b01;
      run_burst(done, ww, a, vm);
      checks++; if (done !== 2'b01) begin errors++; $display("FAIL rmg_pre_done: got %b want 01", done); end
      p_rd_req = 2'b10;
      tick();
      checks++; if (rd_burst_req !== 1'b1) begin errors++; $display("FAIL rmg_grant: got %0b want 1", rd_burst_req); end
      tick();
      tick();
      rst = 1'b1;
      tick();
      checks++; if (rd_burst_req !== 1'b0) begin errors++; $display("FAIL rmg_req_drop: got %0b want 0", rd_burst_req); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmg_busy: got %0b want 0", busy); end
      checks++; if (p_done !== 2'b00) begin errors++; $display("FAIL rmg_done: got %b want 00", p_done); end
      rst = 1'b0;
      p_rd_req = 2'b00;
      tick();
      checks++; if (p_done !== 2'b00) begin errors++; $display("FAIL rmg_no_done: got %b want 00", p_done); end
      p_rd_req = 2'b11;
      run_burst(done, ww, a, vm);
      checks++; if (done !== 2'b01) begin errors++; $display("FAIL rmg_ptr_reset: got %b want 01", done); end
      p_rd_req = 2'b00;
      tick(); tick(); tick();
   endtask

   initial begin
      test_reset();
      test_write();
      test_rr_alternate();
      test_wr_then_rd();
      test_timeout();
      test_fin_at_expiry();
      test_reset_mid_grant();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
